// File: rtl/keccak_src_feeder_if.sv
// Bundle of command, message-word and Keccak-source handshake signals for keccak_src_feeder.
// The master side drives commands, message words and src_read; the slave side is the feeder.
interface keccak_src_feeder_if #(parameter int LEN_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_final;
  logic [31:0]      din;
  logic             din_valid;
  logic             din_ready;
  logic [31:0]      dout;
  logic             src_ready;
  logic             src_read;
  logic             busy;

  modport master (
    output cmd_valid, cmd_mode, cmd_len, cmd_final, din, din_valid, src_read,
    input  cmd_ready, din_ready, dout, src_ready, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_len, cmd_final, din, din_valid, src_read,
    output cmd_ready, din_ready, dout, src_ready, busy
  );
endinterface

// File: rtl/keccak_src_feeder.sv
// Producer end of the Keccak input word port: presents a header word, then the
// byte-masked message words of one hash segment, drawn from a show-ahead FIFO.
module keccak_src_feeder #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  keccak_src_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LEN_W - 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t           state, state_nx;
  logic [31:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, fill;
  logic             full, empty, push, pop;
  logic [1:0]       mode_q;
  logic             final_q;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    rem_q, nwords;
  logic             cmd_fire, last_word;
  logic [31:0]      hdr_word, lane_mask, data_word;

  assign fill      = wr_ptr - rd_ptr;
  assign full      = (fill == (AW+1)'(DEPTH));
  assign empty     = (fill == '0);
  assign push      = bus.din_valid & ~full;
  assign pop       = (state == DATA) & bus.src_read & ~empty;
  assign cmd_fire  = (state == IDLE) & bus.cmd_valid;
  assign last_word = (rem_q == CW'(1));

  // ceil(len/4) fits in LEN_W-1 bits even for len = 2^LEN_W-1
  assign nwords = {1'b0, bus.cmd_len[LEN_W-1:2]} + CW'(|bus.cmd_len[1:0]);

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      state   <= IDLE;
      mode_q  <= '0;
      final_q <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (cmd_fire) begin
        mode_q  <= bus.cmd_mode;
        final_q <= bus.cmd_final;
        len_q   <= bus.cmd_len;
        rem_q   <= nwords;
      end
    end
  end

  always_comb begin
    hdr_word                = '0;
    hdr_word[31:30]         = mode_q;
    hdr_word[29]            = final_q;
    hdr_word[LEN_W+2:0]     = {len_q, 3'b000};
  end

  always_comb begin
    case (len_q[1:0])
      2'd1:    lane_mask = 32'h0000_00FF;
      2'd2:    lane_mask = 32'h0000_FFFF;
      2'd3:    lane_mask = 32'h00FF_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign data_word = mem[rd_ptr[AW-1:0]] & (last_word ? lane_mask : 32'hFFFF_FFFF);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx      = state;
    bus.src_ready = 1'b0;
    bus.dout      = '0;
    case (state)
      IDLE: if (bus.cmd_valid) state_nx = HDR;
      HDR: begin
        bus.src_ready = 1'b1;
        bus.dout      = hdr_word;
        if (bus.src_read) state_nx = (rem_q != '0) ? DATA : IDLE;
      end
      DATA: begin
        bus.src_ready = ~empty;
        bus.dout      = empty ? 32'h0 : data_word;
        if (pop && last_word) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.din_ready = ~full;
  assign bus.busy      = (state != IDLE);
endmodule
